// File: rtl/sd_pkg.sv
// Shared constants and state encoding for the SD sector saver and loader.
// A sector holds 128 words of 32 bits; the image header (word count) is word 0 of sector 0.
package sd_pkg;

  localparam int SEKTOR_BITS      = 4096;
  localparam int WORTE_PRO_SEKTOR = 128;
  localparam int WORT_BITS        = 32;
  localparam int ZAEHLER_BITS     = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    COLLECT,
    SEND,
    WAITING,
    DONE
  } sd_state_t;

endpackage

// File: rtl/sektor_puffer.sv
// 4096-bit sector buffer: words shift in from the top so the first word lands at the LSB.
// Clear and shift may coincide; the shifted word then enters an empty buffer.
module sektor_puffer
  import sd_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clear,
  input  logic                    i_shift,
  input  logic [WORT_BITS-1:0]    i_word,
  output logic [SEKTOR_BITS-1:0]  o_data,
  output logic [ZAEHLER_BITS-1:0] o_count
);

  logic [SEKTOR_BITS-1:0]  r_data;
  logic [ZAEHLER_BITS-1:0] r_count;
  logic [SEKTOR_BITS-1:0]  w_base;
  logic [ZAEHLER_BITS-1:0] w_countBase;

  always_comb begin
    w_base      = i_clear ? '0 : r_data;
    w_countBase = i_clear ? '0 : r_count;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_count <= '0;
    end else if (i_shift) begin
      r_data  <= {i_word, w_base[SEKTOR_BITS-1:WORT_BITS]};
      r_count <= w_countBase + 1'b1;
    end else if (i_clear) begin
      r_data  <= '0;
      r_count <= '0;
    end
  end

  assign o_data  = r_data;
  assign o_count = r_count;

endmodule

// File: rtl/sd_saver.sv
// Saves a block of RAM words to the SD card as consecutive sectors in boot-image format.
// One RAM word is read at a time; the sector buffer is handed to the SD controller when full.
module sd_saver
  import sd_pkg::*;
#(
  parameter int          RAM_LATENZ   = 1,
  parameter logic [31:0] START_SEKTOR = 32'd0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_Start,
  input  logic [31:0]            i_RAMStart,
  input  logic [31:0]            i_Anzahl,
  output logic [31:0]            o_RAMAdresse,
  output logic                   o_RAMLesen,
  input  logic [31:0]            i_DatenRein,
  output logic [31:0]            o_SDAdresse,
  output logic                   o_Schreiben,
  output logic [SEKTOR_BITS-1:0] o_Daten,
  input  logic                   i_Busy,
  input  logic                   i_Fertig,
  output logic                   o_Beschaeftigt,
  output logic                   o_SpeichernFertig
);

  localparam logic [7:0]              LAT    = 8'(RAM_LATENZ);
  localparam logic [ZAEHLER_BITS-1:0] VOLL   = ZAEHLER_BITS'(WORTE_PRO_SEKTOR);
  localparam logic [ZAEHLER_BITS-1:0] LETZTE = ZAEHLER_BITS'(WORTE_PRO_SEKTOR - 1);

  sd_state_t r_state;
  logic [31:0] r_basis;
  logic [31:0] r_anzahl;
  logic [31:0] r_gelesen;
  logic [31:0] r_sektorAdresse;
  logic [7:0]  r_warte;
  logic [31:0] r_RAMAdresse;
  logic        r_RAMLesen;
  logic        r_Schreiben;
  logic        r_Beschaeftigt;
  logic        r_SpeichernFertig;

  logic                    w_clear;
  logic                    w_shift;
  logic [WORT_BITS-1:0]    w_word;
  logic [SEKTOR_BITS-1:0]  w_puffer;
  logic [ZAEHLER_BITS-1:0] w_count;
  logic                    w_rest;

  assign w_rest = (r_gelesen != r_anzahl);

  // Buffer control: header on start, zero padding once the RAM words run out.
  always_comb begin
    w_clear = 1'b0;
    w_shift = 1'b0;
    w_word  = '0;
    case (r_state)
      IDLE, DONE: begin
        if (i_Start) begin
          w_clear = 1'b1;
          w_shift = 1'b1;
          w_word  = i_Anzahl;
        end
      end
      FETCH:   w_shift = !w_rest && (w_count != VOLL);
      COLLECT: begin
        if (r_warte == LAT) begin
          w_shift = 1'b1;
          w_word  = i_DatenRein;
        end
      end
      WAITING: w_clear = i_Fertig && w_rest;
      default: ;
    endcase
  end

  sektor_puffer u_puffer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (w_clear),
    .i_shift (w_shift),
    .i_word  (w_word),
    .o_data  (w_puffer),
    .o_count (w_count)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state           <= IDLE;
      r_basis           <= '0;
      r_anzahl          <= '0;
      r_gelesen         <= '0;
      r_sektorAdresse   <= '0;
      r_warte           <= '0;
      r_RAMAdresse      <= '0;
      r_RAMLesen        <= 1'b0;
      r_Schreiben       <= 1'b0;
      r_Beschaeftigt    <= 1'b0;
      r_SpeichernFertig <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (i_Start) begin
            r_basis           <= i_RAMStart;
            r_anzahl          <= i_Anzahl;
            r_gelesen         <= '0;
            r_sektorAdresse   <= START_SEKTOR;
            r_Beschaeftigt    <= 1'b1;
            r_SpeichernFertig <= 1'b0;
            r_state           <= FETCH;
          end
        end
        FETCH: begin
          if (w_count == VOLL) begin
            r_Schreiben <= 1'b1;
            r_state     <= SEND;
          end else if (w_rest) begin
            r_RAMAdresse <= r_basis + r_gelesen;
            r_RAMLesen   <= 1'b1;
            r_warte      <= '0;
            r_state      <= COLLECT;
          end
        end
        COLLECT: begin
          r_RAMLesen <= 1'b0;
          if (r_warte == LAT) begin
            r_gelesen <= r_gelesen + 32'd1;
            if (w_count == LETZTE) begin
              r_Schreiben <= 1'b1;
              r_state     <= SEND;
            end else begin
              r_state <= FETCH;
            end
          end else begin
            r_warte <= r_warte + 8'd1;
          end
        end
        SEND: begin
          if (i_Busy) begin
            r_Schreiben <= 1'b0;
            r_state     <= WAITING;
          end
        end
        WAITING: begin
          // The last sector is the one sent after every RAM word has been read.
          if (i_Fertig) begin
            if (w_rest) begin
              r_sektorAdresse <= r_sektorAdresse + 32'd1;
              r_state         <= FETCH;
            end else begin
              r_Beschaeftigt    <= 1'b0;
              r_SpeichernFertig <= 1'b1;
              r_state           <= DONE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_RAMAdresse      = r_RAMAdresse;
  assign o_RAMLesen        = r_RAMLesen;
  assign o_SDAdresse       = r_sektorAdresse;
  assign o_Schreiben       = r_Schreiben;
  assign o_Daten           = w_puffer;
  assign o_Beschaeftigt    = r_Beschaeftigt;
  assign o_SpeichernFertig = r_SpeichernFertig;

endmodule
